// File: rtl/wb_uart_tx_pkg.sv
// Shared register offsets, STATUS bit positions, serializer state encoding and
// the clog2 helper for the Wishbone UART transmitter.
package wb_uart_tx_pkg;

  localparam logic [1:0] UART_TX_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_TX_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_TX_REG_DIV    = 2'd2;
  localparam logic [1:0] UART_TX_REG_CTRL   = 2'd3;

  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT  = 2;
  localparam int unsigned STATUS_COUNT_LSB = 8;
  localparam int unsigned STATUS_COUNT_W   = 8;

  localparam int unsigned DIV_W   = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned MAPSZ   = 16;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned x;
    res = 0;
    x   = (value > 0) ? value - 1 : 0;
    while (x > 0) begin
      res = res + 1;
      x   = x >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone peripheral slave port bundle for the UART transmitter.
interface wb_uart_tx_if
  import wb_uart_tx_pkg::*;
#(
  parameter int unsigned ARCHBITSZ = 32
);
  localparam int unsigned ADDR_W = ARCHBITSZ - clog2(ARCHBITSZ / 8);
  localparam int unsigned SEL_W  = ARCHBITSZ / 8;

  logic                 wb_cyc_i;
  logic                 wb_stb_i;
  logic                 wb_we_i;
  logic [ADDR_W-1:0]    wb_addr_i;
  logic [SEL_W-1:0]     wb_sel_i;
  logic [ARCHBITSZ-1:0] wb_dat_i;
  logic                 wb_bsy_o;
  logic                 wb_ack_o;
  logic [ARCHBITSZ-1:0] wb_dat_o;
  logic [ARCHBITSZ-1:0] wb_mapsz_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_dat_i,
    input  wb_bsy_o, wb_ack_o, wb_dat_o, wb_mapsz_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_dat_i,
    output wb_bsy_o, wb_ack_o, wb_dat_o, wb_mapsz_o
  );

endinterface

// File: rtl/wb_uart_tx_fifo.sv
// Synchronous byte FIFO with full/empty flags and occupancy count.
module wb_uart_tx_fifo
  import wb_uart_tx_pkg::*;
#(
  parameter int unsigned BUFSZ = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [BYTE_W-1:0]          wdata,
  output logic [BYTE_W-1:0]          rdata_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [clog2(BUFSZ):0]      count
);
  localparam int unsigned PTR_W = clog2(BUFSZ);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] mem [BUFSZ];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push_c;
  logic              do_pop_c;

  assign full_c    = (count == CNT_W'(BUFSZ));
  assign empty_c   = (count == '0);
  assign do_push_c = push & ~full_c;
  assign do_pop_c  = pop & ~empty_c;
  assign rdata_c   = mem[rd_ptr];

  // Pointers wrap naturally because BUFSZ is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone UART transmitter: TX byte FIFO drained by an 8N1 bit-timer/serializer onto tx_o.
// Define UART_TX_IRQ_EN to add the CTRL register at 0xC and the irq_o output.
module wb_uart_tx
  import wb_uart_tx_pkg::*;
#(
  parameter int unsigned ARCHBITSZ = 32,
  parameter int unsigned CLKFREQ   = 100000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned BUFSZ     = 16
) (
  input  logic        rst_i,
  input  logic        clk_i,
  wb_uart_tx_if.slave wb,
  output logic        tx_o
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq_o
`endif
);
  localparam int unsigned ADDR_W = ARCHBITSZ - clog2(ARCHBITSZ / 8);
  localparam int unsigned CNT_W  = clog2(BUFSZ) + 1;
  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(CLKFREQ / BAUD - 1);

  logic [1:0]           reg_sel_c;
  logic                 req_c;
  logic                 wr_c;
  logic                 bsy_c;
  logic                 accept_c;
  logic                 push_c;
  logic                 div_wr_c;
  logic                 pop_c;
  logic [ARCHBITSZ-1:0] rdata_c;

  logic [BYTE_W-1:0]    fifo_rdata_c;
  logic                 fifo_full_c;
  logic                 fifo_empty_c;
  logic [CNT_W-1:0]     fifo_count;

  logic [DIV_W-1:0]     div_q;
  ser_state_e           state_q, state_d;
  logic [DIV_W-1:0]     timer_q, timer_d;
  logic [BYTE_W-1:0]    shreg_q, shreg_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_d;

  logic                 unused_bits;
  assign unused_bits = ^{wb.wb_addr_i[ADDR_W-1:2], wb.wb_dat_i[ARCHBITSZ-1:DIV_W]};

  // Bus decode: only a real DATA write into a full FIFO stalls.
  assign reg_sel_c     = wb.wb_addr_i[1:0];
  assign req_c         = wb.wb_cyc_i & wb.wb_stb_i;
  assign wr_c          = wb.wb_we_i & (|wb.wb_sel_i);
  assign bsy_c         = req_c & wr_c & (reg_sel_c == UART_TX_REG_DATA) & fifo_full_c;
  assign accept_c      = req_c & ~bsy_c;
  assign push_c        = accept_c & wr_c & (reg_sel_c == UART_TX_REG_DATA);
  assign div_wr_c      = accept_c & wr_c & (reg_sel_c == UART_TX_REG_DIV);
  assign wb.wb_bsy_o   = bsy_c;
  assign wb.wb_mapsz_o = ARCHBITSZ'(MAPSZ);

  wb_uart_tx_fifo #(.BUFSZ(BUFSZ)) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   (wb.wb_dat_i[BYTE_W-1:0]),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .count   (fifo_count)
  );

`ifdef UART_TX_IRQ_EN
  logic irq_en_q;
  logic irq_en_d;
  logic ctrl_wr_c;

  assign ctrl_wr_c = accept_c & wr_c & (reg_sel_c == UART_TX_REG_CTRL);
  assign irq_en_d  = ctrl_wr_c ? wb.wb_dat_i[0] : irq_en_q;

  // A push in flight already means the FIFO will not be empty next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en_q <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_o    <= irq_en_d & fifo_empty_c & ~push_c & (state_q == SER_IDLE);
    end
  end
`endif

  always_comb begin
    rdata_c = '0;
    case (reg_sel_c)
      UART_TX_REG_STATUS: begin
        rdata_c[STATUS_FULL_BIT]  = fifo_full_c;
        rdata_c[STATUS_EMPTY_BIT] = fifo_empty_c;
        rdata_c[STATUS_BUSY_BIT]  = (state_q != SER_IDLE);
        rdata_c[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
      end
      UART_TX_REG_DIV: rdata_c[DIV_W-1:0] = div_q;
`ifdef UART_TX_IRQ_EN
      UART_TX_REG_CTRL: rdata_c[0] = irq_en_q;
`endif
      default: rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      div_q       <= RESET_DIV;
    end else begin
      wb.wb_ack_o <= accept_c;
      wb.wb_dat_o <= (accept_c & ~wb.wb_we_i) ? rdata_c : '0;
      if (div_wr_c) div_q <= wb.wb_dat_i[DIV_W-1:0];
    end
  end

  // Serializer: every state lasts div_q+1 clocks; the divisor is sampled at each reload.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    pop_c     = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          shreg_d = fifo_rdata_c;
          timer_d = div_q;
          state_d = SER_START;
        end
      end
      SER_START: begin
        if (timer_q == '0) begin
          timer_d   = div_q;
          bit_idx_d = 3'd0;
          state_d   = SER_DATA;
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      SER_DATA: begin
        if (timer_q == '0) begin
          timer_d   = div_q;
          shreg_d   = {1'b0, shreg_q[BYTE_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = SER_STOP;
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      SER_STOP: begin
        if (timer_q == '0) state_d = SER_IDLE;
        else               timer_d = timer_q - DIV_W'(1);
      end
      default: state_d = SER_IDLE;
    endcase
    case (state_d)
      SER_START: tx_d = 1'b0;
      SER_DATA:  tx_d = shreg_d[0];
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SER_IDLE;
      timer_q   <= '0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_o      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tx_o      <= tx_d;
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: bus-level stimulus, serial line decoded by a
// sample-level 8N1 receiver model and compared against the bytes written.
module tb_wb_uart_tx;
  localparam int unsigned ARCHBITSZ = 32;
  localparam int unsigned CLKFREQ   = 100000000;
  localparam int unsigned BAUD      = 115200;
  localparam int unsigned BUFSZ     = 16;
  localparam int unsigned RESET_DIV = CLKFREQ / BAUD - 1;
  localparam logic [1:0]  A_DATA    = 2'd0;
  localparam logic [1:0]  A_STATUS  = 2'd1;
  localparam logic [1:0]  A_DIV     = 2'd2;
  localparam logic [1:0]  A_CTRL    = 2'd3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic tx_o;
`ifdef UART_TX_IRQ_EN
  logic irq_o;
`endif

  int errors = 0;
  int checks = 0;

  logic       capture = 1'b0;
  logic       tx_log[$];
  logic [7:0] dec_q[$];
  int         dec_terr;
  int         dec_gap;

  always #5 clk_i = ~clk_i;

  wb_uart_tx_if #(.ARCHBITSZ(ARCHBITSZ)) wb();

  wb_uart_tx #(
    .ARCHBITSZ(ARCHBITSZ), .CLKFREQ(CLKFREQ), .BAUD(BAUD), .BUFSZ(BUFSZ)
  ) dut (
    .rst_i (rst_i),
    .clk_i (clk_i),
    .wb    (wb),
    .tx_o  (tx_o)
`ifdef UART_TX_IRQ_EN
    ,
    .irq_o (irq_o)
`endif
  );

  always @(negedge clk_i) if (capture) tx_log.push_back(tx_o);

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic bus_idle();
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_addr_i = '0; wb.wb_sel_i = '0; wb.wb_dat_i = '0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] sel,
                          output int stalls, output logic acked);
    @(posedge clk_i); #1;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_addr_i = 30'(a); wb.wb_sel_i = sel; wb.wb_dat_i = d;
    stalls = 0;
    @(negedge clk_i);
    while (wb.wb_bsy_o === 1'b1 && stalls < 2000) begin
      stalls++;
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    bus_idle();
    @(negedge clk_i);
    acked = wb.wb_ack_o;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d, output logic acked);
    @(posedge clk_i); #1;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
    wb.wb_addr_i = 30'(a); wb.wb_sel_i = 4'hF; wb.wb_dat_i = '0;
    @(posedge clk_i); #1;
    bus_idle();
    @(negedge clk_i);
    acked = wb.wb_ack_o;
    d = wb.wb_dat_o;
  endtask

  task automatic wait_tx_low(output int found);
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (tx_o === 1'b0) begin found = 1; break; end
    end
  endtask

  // Reference 8N1 receiver: slices the captured line into frames of (div+1)-sample bits.
  task automatic decode_log(input int div);
    int i, gap, per;
    bit seen;
    logic [7:0] v;
    per = div + 1; i = 0; gap = 0; seen = 0;
    dec_q.delete(); dec_terr = 0; dec_gap = 0;
    while (i < tx_log.size()) begin
      if (tx_log[i] !== 1'b0) begin
        gap++; i++;
      end else if (i + 10 * per > tx_log.size()) begin
        dec_terr++; i = tx_log.size();
      end else begin
        if (seen && gap > dec_gap) dec_gap = gap;
        seen = 1;
        for (int b = 0; b < 10; b++)
          for (int k = 0; k < per; k++)
            if (tx_log[i + b * per + k] !== tx_log[i + b * per]) dec_terr++;
        for (int b = 0; b < 8; b++) v[b] = tx_log[i + (b + 1) * per];
        if (tx_log[i + 9 * per] !== 1'b1) dec_terr++;
        dec_q.push_back(v);
        i += 10 * per; gap = 0;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd, val;
    logic ack;
    int st;
    bus_idle();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_o); end
    checks++; if (wb.wb_ack_o !== 1'b0 || wb.wb_dat_o !== 32'd0 || wb.wb_bsy_o !== 1'b0) begin
      errors++; $display("FAIL reset_bus: ack=%b dat=%h bsy=%b want 0/0/0", wb.wb_ack_o, wb.wb_dat_o, wb.wb_bsy_o); end
    rst_i = 1'b0;
    checks++; if (wb.wb_mapsz_o !== 32'd16) begin errors++; $display("FAIL mapsz: got %0d want 16", wb.wb_mapsz_o); end
    wb_read(A_STATUS, rd, ack);
    checks++; if (rd !== 32'h2 || ack !== 1'b1) begin errors++; $display("FAIL reset_status: got %h ack=%b want 00000002 ack=1", rd, ack); end
    wb_read(A_DIV, rd, ack);
    checks++; if (rd !== 32'(RESET_DIV)) begin errors++; $display("FAIL reset_div: got %0d want %0d", rd, RESET_DIV); end
    @(negedge clk_i);
    checks++; if (wb.wb_ack_o !== 1'b0 || wb.wb_dat_o !== 32'd0) begin
      errors++; $display("FAIL dat_after_ack: ack=%b dat=%h want 0/0", wb.wb_ack_o, wb.wb_dat_o); end
    val = 32'($urandom_range(0, 65535));
    wb_write(A_DIV, val | 32'hABCD_0000, 4'hF, st, ack);
    wb_read(A_DIV, rd, ack);
    checks++; if (rd !== val) begin errors++; $display("FAIL div_rw: got %h want %h", rd, val); end
    wb_write(A_DIV, ~val, 4'h0, st, ack);
    wb_read(A_DIV, rd, ack);
    checks++; if (rd !== val) begin errors++; $display("FAIL div_sel0: got %h want %h", rd, val); end
    wb_write(A_DATA, 32'h5A, 4'h0, st, ack);
    wb_read(A_STATUS, rd, ack);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL data_sel0: status %h want 00000002", rd); end
    val = $urandom;
    wb_write(A_CTRL, val, 4'hF, st, ack);
    wb_read(A_CTRL, rd, ack);
`ifdef UART_TX_IRQ_EN
    checks++; if (rd !== {31'd0, val[0]}) begin errors++; $display("FAIL ctrl_rw: got %h want %h", rd, {31'd0, val[0]}); end
    wb_write(A_CTRL, 32'd0, 4'hF, st, ack);
`else
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reg_c: got %h want 0", rd); end
`endif
  endtask

  task automatic test_single_byte();
    logic [31:0] rd;
    logic [9:0]  frame;
    logic [7:0]  b2;
    logic ack;
    int st, s, mism;
    wb_write(A_DIV, 32'd3, 4'hF, st, ack);
    b2 = 8'($urandom);
    tx_log.delete(); capture = 1'b1;
    wb_write(A_DATA, 32'h55, 4'hF, st, ack);
    wb_write(A_DATA, {24'd0, b2}, 4'hF, st, ack);
    repeat (110) @(negedge clk_i);
    capture = 1'b0;
    decode_log(3);
    checks++; if (dec_q.size() != 2 || dec_terr != 0) begin
      errors++; $display("FAIL single_frames: frames=%0d timing_err=%0d want 2/0", dec_q.size(), dec_terr); end
    if (dec_q.size() == 2) begin
      checks++; if (dec_q[0] !== 8'h55 || dec_q[1] !== b2) begin
        errors++; $display("FAIL single_bytes: got %h %h want 55 %h", dec_q[0], dec_q[1], b2); end
    end
    s = -1;
    for (int i = 0; i < tx_log.size(); i++) if (tx_log[i] === 1'b0) begin s = i; break; end
    frame = {1'b1, 8'h55, 1'b0};
    mism = 0;
    if (s < 0 || s + 40 > tx_log.size()) mism = 40;
    else for (int j = 0; j < 40; j++) if (tx_log[s + j] !== frame[j / 4]) mism++;
    checks++; if (mism !== 0) begin errors++; $display("FAIL wave_55: %0d of 40 samples wrong, want 0", mism); end
    wb_read(A_STATUS, rd, ack);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL status_after: got %h want 00000002", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_q[$];
    logic [31:0] rd;
    logic [7:0]  b;
    logic ack;
    int st, stall_sum, ack_cnt;
    wb_write(A_DIV, 32'd3, 4'hF, st, ack);
    tx_log.delete(); capture = 1'b1;
    stall_sum = 0; ack_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wb_write(A_DATA, {24'd0, b}, 4'hF, st, ack);
      stall_sum += st;
      if (ack === 1'b1) ack_cnt++;
    end
    checks++; if (stall_sum != 0 || ack_cnt != 17) begin
      errors++; $display("FAIL b2b_fill: stalls=%0d acks=%0d want 0/17", stall_sum, ack_cnt); end
    // One byte is already in the shifter, so the FIFO holds exactly BUFSZ now.
    wb_read(A_STATUS, rd, ack);
    checks++; if (rd !== 32'h0000_1005) begin errors++; $display("FAIL b2b_full_status: got %h want 00001005", rd); end
    b = 8'($urandom);
    exp_q.push_back(b);
    wb_write(A_DATA, {24'd0, b}, 4'hF, st, ack);
    checks++; if (st < 1 || st > 60 || ack !== 1'b1) begin
      errors++; $display("FAIL b2b_stall: stalls=%0d ack=%b want 1..60 / 1", st, ack); end
    repeat (18 * 41 + 60) @(negedge clk_i);
    capture = 1'b0;
    decode_log(3);
    checks++; if (dec_q.size() != 18 || dec_terr != 0 || dec_gap != 1) begin
      errors++; $display("FAIL b2b_frames: frames=%0d terr=%0d gap=%0d want 18/0/1", dec_q.size(), dec_terr, dec_gap); end
    for (int i = 0; i < 18 && i < dec_q.size(); i++) begin
      checks++; if (dec_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, dec_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic ack;
    int st;
    wb_write(A_DIV, 32'd0, 4'hF, st, ack);
    tx_log.delete(); capture = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wb_write(A_DATA, {24'd0, b}, 4'hF, st, ack);
    end
    repeat (100) @(negedge clk_i);
    capture = 1'b0;
    decode_log(0);
    checks++; if (dec_q.size() != 5 || dec_terr != 0 || dec_gap != 1) begin
      errors++; $display("FAIL div0_frames: frames=%0d terr=%0d gap=%0d want 5/0/1", dec_q.size(), dec_terr, dec_gap); end
    for (int i = 0; i < 5 && i < dec_q.size(); i++) begin
      checks++; if (dec_q[i] !== exp_q[i]) begin errors++; $display("FAIL div0_byte%0d: got %h want %h", i, dec_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_div_change();
    logic [7:0] b;
    logic exp_bit;
    logic ack;
    int st, found, s, mism;
    wb_write(A_DIV, 32'd7, 4'hF, st, ack);
    b = 8'($urandom) | 8'h01;
    tx_log.delete(); capture = 1'b1;
    wb_write(A_DATA, {24'd0, b}, 4'hF, st, ack);
    wait_tx_low(found);
    checks++; if (found != 1) begin errors++; $display("FAIL divchg_start: no start bit seen, want one"); end
    wb_write(A_DIV, 32'hFFFF, 4'hF, st, ack);
    wb_write(A_DIV, 32'd1, 4'hF, st, ack);
    repeat (60) @(negedge clk_i);
    capture = 1'b0;
    s = -1;
    for (int i = 0; i < tx_log.size(); i++) if (tx_log[i] === 1'b0) begin s = i; break; end
    mism = 0;
    if (s < 0 || s + 26 > tx_log.size()) mism = 26;
    else for (int j = 0; j < 26; j++) begin
      if (j < 8)       exp_bit = 1'b0;
      else if (j < 24) exp_bit = b[(j - 8) / 2];
      else             exp_bit = 1'b1;
      if (tx_log[s + j] !== exp_bit) mism++;
    end
    checks++; if (mism !== 0) begin errors++; $display("FAIL divchg_wave: %0d of 26 samples wrong, want 0", mism); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    logic ack;
    int st, found, lows;
    wb_write(A_DIV, 32'd3, 4'hF, st, ack);
    wb_write(A_DATA, 32'hA5, 4'hF, st, ack);
    wb_write(A_DATA, 32'($urandom_range(0, 255)), 4'hF, st, ack);
    wait_tx_low(found);
    checks++; if (found != 1) begin errors++; $display("FAIL rstmid_start: no start bit seen, want one"); end
    repeat (8) @(negedge clk_i);
    checks++; if (tx_o !== 1'b0) begin errors++; $display("FAIL rstmid_bit1: tx=%b want 0", tx_o); end
    #1 rst_i = 1'b1;
    #1;
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL rstmid_async: tx=%b want 1", tx_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    wb_read(A_STATUS, rd, ack);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL rstmid_status: got %h want 00000002", rd); end
    tx_log.delete(); capture = 1'b1;
    repeat (100) @(negedge clk_i);
    capture = 1'b0;
    lows = 0;
    foreach (tx_log[i]) if (tx_log[i] !== 1'b1) lows++;
    checks++; if (lows != 0) begin errors++; $display("FAIL rstmid_discard: %0d low samples want 0", lows); end
  endtask

`ifdef UART_TX_IRQ_EN
  task automatic test_irq();
    logic ack;
    int st, cnt;
    wb_write(A_DIV, 32'd3, 4'hF, st, ack);
    repeat (5) @(negedge clk_i);
    wb_write(A_CTRL, 32'd1, 4'hF, st, ack);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq_o); end
    wb_write(A_DATA, 32'h41, 4'hF, st, ack);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_busy: got %b want 0", irq_o); end
    cnt = 0;
    while (irq_o !== 1'b1 && cnt < 200) begin @(negedge clk_i); cnt++; end
    // Frame of 10 bits x 4 clocks, plus the pop cycle and the registered flag.
    checks++; if (cnt != 42) begin errors++; $display("FAIL irq_rise: after %0d cycles want 42", cnt); end
    wb_write(A_CTRL, 32'd0, 4'hF, st, ack);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq_o); end
  endtask
`endif

  initial begin
    bus_idle();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_div_zero();
    test_div_change();
    test_reset_mid_frame();
`ifdef UART_TX_IRQ_EN
    test_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
